// File: rtl/div_if.sv
// div_if: operand/result bundle for the sequential signed divider div_seq.
//
// Signals (suffixes are from the divider's point of view):
//   start_i     request, sampled only while the divider is idle
//   dvd_i       signed dividend, W = M_bits+N_bits bits
//   dvr_i       signed divisor, N_bits bits
//   quot_o      signed truncating quotient, W bits
//   rem_o       signed remainder (sign of dividend), N_bits bits
//   busy_o      high while an operation is in progress
//   div_zero_o  last operation had a zero divisor
//   ovf_o       last operation was -2^(W-1) / -1
//
// Modports: master drives the request side, slave is the divider.
interface div_if #(
    parameter int M_bits = 12,
    parameter int N_bits = 8
);
    localparam int W = M_bits + N_bits;

    logic              start_i;
    logic [W-1:0]      dvd_i;
    logic [N_bits-1:0] dvr_i;
    logic [W-1:0]      quot_o;
    logic [N_bits-1:0] rem_o;
    logic              busy_o;
    logic              div_zero_o;
    logic              ovf_o;

    modport master (
        output start_i, dvd_i, dvr_i,
        input  quot_o, rem_o, busy_o, div_zero_o, ovf_o
    );

    modport slave (
        input  start_i, dvd_i, dvr_i,
        output quot_o, rem_o, busy_o, div_zero_o, ovf_o
    );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential signed restoring divider, one quotient bit per clock.
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous active-high reset
//   bus  div_if.slave: start/dvd/dvr request, quot/rem/busy/div_zero/ovf
//
// Works on magnitudes, then restores signs in the FIX state: the quotient
// is negated when operand signs differ, the remainder takes the dividend's
// sign. Busy is high for W+1 cycles (1 cycle for a zero divisor).
module div_seq #(
    parameter int M_bits = 12,
    parameter int N_bits = 8
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int W     = M_bits + N_bits;
    localparam int CNT_W = $clog2(W);
    localparam logic [W-1:0] MIN_MAG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      dvd_q, dvd_d;      // dividend magnitude, becomes quotient
    logic [N_bits-1:0] dvr_q, dvr_d;      // divisor magnitude
    logic [N_bits:0]   part_q, part_d;    // partial remainder
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_dvd_q, neg_dvd_d;
    logic              neg_quot_q, neg_quot_d;
    logic [W-1:0]      quot_q, quot_d;
    logic [N_bits-1:0] rem_q, rem_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;

    logic [N_bits:0]   shifted;
    logic              take;

    // Magnitude of the most negative value wraps to MIN_MAG, which is the
    // correct unsigned magnitude, so no special case is needed.
    logic [W-1:0]      dvd_abs;
    logic [N_bits-1:0] dvr_abs;
    assign dvd_abs = bus.dvd_i[W-1]      ? -bus.dvd_i : bus.dvd_i;
    assign dvr_abs = bus.dvr_i[N_bits-1] ? -bus.dvr_i : bus.dvr_i;

    // The remainder is always below |Dvr| <= 2^(N_bits-1), so shifting in one
    // more bit fits in N_bits+1.
    assign shifted = {part_q[N_bits-1:0], dvd_q[W-1]};
    assign take    = shifted >= {1'b0, dvr_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dvd_q      <= '0;
            dvr_q      <= '0;
            part_q     <= '0;
            cnt_q      <= '0;
            neg_dvd_q  <= 1'b0;
            neg_quot_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples the pre-edge
            // values computed by the combinational block.
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvr_q      <= dvr_d;
            part_q     <= part_d;
            cnt_q      <= cnt_d;
            neg_dvd_q  <= neg_dvd_d;
            neg_quot_q <= neg_quot_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvr_d      = dvr_q;
        part_d     = part_q;
        cnt_d      = cnt_q;
        neg_dvd_d  = neg_dvd_q;
        neg_quot_d = neg_quot_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    dvd_d      = dvd_abs;
                    dvr_d      = dvr_abs;
                    part_d     = '0;
                    cnt_d      = '0;
                    neg_dvd_d  = bus.dvd_i[W-1];
                    neg_quot_d = bus.dvd_i[W-1] ^ bus.dvr_i[N_bits-1];
                    dz_d       = 1'b0;
                    ovf_d      = 1'b0;
                    state_d    = (bus.dvr_i == '0) ? FIX : DIV;
                end
            end
            DIV: begin
                part_d = take ? shifted - {1'b0, dvr_q} : shifted;
                dvd_d  = {dvd_q[W-2:0], take};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W-1)) state_d = FIX;
            end
            FIX: begin
                if (dvr_q == '0) begin
                    // dvd_q still holds |Dvd|; re-applying the sign gives back
                    // the original low bits of Dvd.
                    quot_d = '0;
                    rem_d  = neg_dvd_q ? -dvd_q[N_bits-1:0] : dvd_q[N_bits-1:0];
                    dz_d   = 1'b1;
                end else begin
                    quot_d = neg_quot_q ? -dvd_q : dvd_q;
                    rem_d  = neg_dvd_q ? -part_q[N_bits-1:0] : part_q[N_bits-1:0];
                    // A positive quotient magnitude of 2^(W-1) only arises from
                    // -2^(W-1) / -1; it wraps to -2^(W-1) on its own.
                    ovf_d  = (dvd_q == MIN_MAG) && !neg_quot_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy_o     = (state_q != IDLE);
    assign bus.quot_o     = quot_q;
    assign bus.rem_o      = rem_q;
    assign bus.div_zero_o = dz_q;
    assign bus.ovf_o      = ovf_q;
endmodule
